hall_conditioner: RTL and testbench

Front-end stage for the BLDC driver: synchronises and debounces the three raw Hall inputs, then decodes them into a rotor sector, direction, per-step pulse and commutation period. Filtered Hall lines feed the existing commutation/gate-drive block (MAIN) directly. SECTOR, DIR, PERIOD and STALL go to speed/supervision logic. Sits between the board pins and MAIN in the same CLK domain.

---
 rtl/bldc_pkg.sv | 95 +++++++++
 rtl/hall_filter.sv | 80 ++++++++
 rtl/hall_conditioner.sv | 149 ++++++++++++++
 tb/tb_hall_conditioner.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// -----------------------------------------------------------------------------
// bldc_pkg
// Shared definitions for the BLDC driver blocks.
//   - hall_code_t / sector_t : 3-bit Hall code {H3,H2,H1} and rotor sector
//   - SEC_NONE .. SEC_6      : sector encodings (0 = unknown/invalid)
//   - FWD_SEQ                : Hall codes in forward rotation order, sector 1..6
//   - trans_t                : classification of an accepted code change
//   - hall_to_sector()       : Hall code -> sector (invalid code -> SEC_NONE)
//   - sector_next/prev()     : neighbouring sectors with wrap-around
//   - classify()             : sector change -> forward / reverse / fault / none
// -----------------------------------------------------------------------------
package bldc_pkg;

    typedef logic [2:0] hall_code_t;
    typedef logic [2:0] sector_t;

    localparam sector_t SEC_NONE = 3'd0;
    localparam sector_t SEC_1    = 3'd1;
    localparam sector_t SEC_2    = 3'd2;
    localparam sector_t SEC_3    = 3'd3;
    localparam sector_t SEC_4    = 3'd4;
    localparam sector_t SEC_5    = 3'd5;
    localparam sector_t SEC_6    = 3'd6;

    // Index i holds the Hall code of sector i+1.
    localparam hall_code_t FWD_SEQ [6] = '{3'b001, 3'b101, 3'b100,
                                           3'b110, 3'b010, 3'b011};

    typedef enum logic [1:0] {
        TR_NONE  = 2'd0,   // no change, or sector merely established
        TR_FWD   = 2'd1,   // adjacent step, forward
        TR_REV   = 2'd2,   // adjacent step, reverse
        TR_FAULT = 2'd3    // jump of 2/3 sectors or entry into an invalid code
    } trans_t;

    function automatic sector_t hall_to_sector(input hall_code_t code);
        sector_t sec;
        sec = SEC_NONE;
        for (int i = 0; i < 6; i++) begin
            if (code == FWD_SEQ[i]) begin
                sec = sector_t'(i + 1);
            end
        end
        return sec;
    endfunction

    function automatic sector_t sector_next(input sector_t s);
        sector_t n;
        case (s)
            SEC_1:   n = SEC_2;
            SEC_2:   n = SEC_3;
            SEC_3:   n = SEC_4;
            SEC_4:   n = SEC_5;
            SEC_5:   n = SEC_6;
            SEC_6:   n = SEC_1;
            default: n = SEC_NONE;
        endcase
        return n;
    endfunction

    function automatic sector_t sector_prev(input sector_t s);
        sector_t p;
        case (s)
            SEC_1:   p = SEC_6;
            SEC_2:   p = SEC_1;
            SEC_3:   p = SEC_2;
            SEC_4:   p = SEC_3;
            SEC_5:   p = SEC_4;
            SEC_6:   p = SEC_5;
            default: p = SEC_NONE;
        endcase
        return p;
    endfunction

    // Leaving SEC_NONE for a valid sector only establishes position, so it is
    // not a fault; entering SEC_NONE always is.
    function automatic trans_t classify(input sector_t from_sec, input sector_t to_sec);
        trans_t t;
        if (to_sec == SEC_NONE) begin
            t = TR_FAULT;
        end else if (from_sec == SEC_NONE) begin
            t = TR_NONE;
        end else if (to_sec == sector_next(from_sec)) begin
            t = TR_FWD;
        end else if (to_sec == sector_prev(from_sec)) begin
            t = TR_REV;
        end else if (to_sec == from_sec) begin
            t = TR_NONE;
        end else begin
            t = TR_FAULT;
        end
        return t;
    endfunction

endpackage

// File: rtl/hall_filter.sv
// -----------------------------------------------------------------------------
// hall_filter
// Synchronises the three raw Hall lines and debounces them as one 3-bit code.
// A code is accepted once DEB_CYCLES consecutive identical synchronised samples
// have been seen; any change restarts the count.
//   clk, rst_n  : clock, asynchronous active-low reset
//   hall_raw    : raw {H3,H2,H1} from the pins
//   acc_code    : currently accepted code (registered)
//   cand_code   : code being qualified; becomes acc_code when acc_load is high
//   acc_load    : high in the cycle whose edge loads cand_code into acc_code
// -----------------------------------------------------------------------------
module hall_filter
    import bldc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  hall_code_t hall_raw,
    output hall_code_t acc_code,
    output hall_code_t cand_code,
    output logic       acc_load
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEB_CYCLES);

    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    hall_code_t                  cand_q, cand_d;
    hall_code_t                  acc_q,  acc_d;
    logic [CNT_W-1:0]            cnt_q,  cnt_d;
    hall_code_t                  smp;
    logic                        load;

    assign smp = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = hall_raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        // cnt_q counts how many consecutive samples equal cand_q; a differing
        // sample becomes the new candidate and is itself the first sample.
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (smp != cand_q) begin
            cand_d = smp;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + 1'b1;
        end

        // The reset value of acc_q (000) is never "loaded", so it cannot be
        // mistaken for a transition into an invalid code.
        load  = (cnt_q == CNT_FULL) && (cand_q != acc_q);
        acc_d = load ? cand_q : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

    assign acc_code  = acc_q;
    assign cand_code = cand_q;
    assign acc_load  = load;

endmodule

// File: rtl/hall_conditioner.sv
// -----------------------------------------------------------------------------
// hall_conditioner
// Front end for the BLDC driver: filtered Hall lines, rotor sector, direction,
// per-step pulse, commutation period and fault/stall supervision.
//   CLK, RST_N         : clock (rising edge), asynchronous active-low reset
//   H1, H2, H3         : raw asynchronous Hall inputs, code = {H3,H2,H1}
//   CLR_FAULT          : synchronous pulse clearing HALL_FAULT
//   H1_OUT..H3_OUT     : accepted Hall levels for the commutation block
//   SECTOR             : 1..6, 0 when the accepted code is invalid/unknown
//   DIR                : 1 forward, 0 reverse (held on faults)
//   STEP               : one-cycle pulse per accepted adjacent sector change
//   PERIOD             : cycles between the last two STEPs (0 while stalled)
//   STALL              : no valid speed measurement available
//   HALL_FAULT         : sticky fault flag
// -----------------------------------------------------------------------------
module hall_conditioner
    import bldc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int PER_W       = 20
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             H1,
    input  logic             H2,
    input  logic             H3,
    input  logic             CLR_FAULT,
    output logic             H1_OUT,
    output logic             H2_OUT,
    output logic             H3_OUT,
    output logic [2:0]       SECTOR,
    output logic             DIR,
    output logic             STEP,
    output logic [PER_W-1:0] PERIOD,
    output logic             STALL,
    output logic             HALL_FAULT
);

    localparam logic [PER_W-1:0] CNT_MAX = '1;

    function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    hall_code_t acc_code;
    hall_code_t cand_code;
    logic       acc_load;

    hall_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_filter (
        .clk       (CLK),
        .rst_n     (RST_N),
        .hall_raw  ({H3, H2, H1}),
        .acc_code  (acc_code),
        .cand_code (cand_code),
        .acc_load  (acc_load)
    );

    sector_t          sector_q, sector_d;
    logic             dir_q,    dir_d;
    logic             step_q,   step_d;
    logic [PER_W-1:0] cnt_q,    cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             stall_q,  stall_d;
    logic             fault_q,  fault_d;

    sector_t old_sec;
    sector_t new_sec;
    trans_t  trans;
    logic    step_evt;
    logic    fault_evt;

    always_comb begin
        old_sec   = hall_to_sector(acc_code);
        new_sec   = hall_to_sector(cand_code);
        trans     = acc_load ? classify(old_sec, new_sec) : TR_NONE;
        step_evt  = (trans == TR_FWD) || (trans == TR_REV);
        fault_evt = (trans == TR_FAULT);

        sector_d = acc_load ? new_sec : sector_q;
        step_d   = step_evt;

        dir_d = dir_q;
        if (trans == TR_FWD) begin
            dir_d = 1'b1;
        end else if (trans == TR_REV) begin
            dir_d = 1'b0;
        end

        cnt_d = step_evt ? '0 : sat_inc(cnt_q);

        // A STEP while stalled only arms the measurement. A STEP coinciding
        // with saturation still reports (saturated) period and stays armed.
        period_d = period_q;
        stall_d  = stall_q;
        if (step_evt) begin
            if (!stall_q) begin
                period_d = sat_inc(cnt_q);
            end
            stall_d = 1'b0;
        end else if (fault_evt || (cnt_d == CNT_MAX)) begin
            period_d = '0;
            stall_d  = 1'b1;
        end

        // Set wins over a clear arriving in the same cycle.
        if (fault_evt) begin
            fault_d = 1'b1;
        end else if (CLR_FAULT) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sector_q <= SEC_NONE;
            dir_q    <= 1'b1;
            step_q   <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            stall_q  <= 1'b1;
            fault_q  <= 1'b0;
        end else begin
            sector_q <= sector_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            stall_q  <= stall_d;
            fault_q  <= fault_d;
        end
    end

    assign H1_OUT     = acc_code[0];
    assign H2_OUT     = acc_code[1];
    assign H3_OUT     = acc_code[2];
    assign SECTOR     = sector_q;
    assign DIR        = dir_q;
    assign STEP       = step_q;
    assign PERIOD     = period_q;
    assign STALL      = stall_q;
    assign HALL_FAULT = fault_q;

endmodule

// File: tb/tb_hall_conditioner.sv
// -----------------------------------------------------------------------------
// tb_hall_conditioner
// Directed bench for hall_conditioner with SYNC_STAGES=2, DEB_CYCLES=4,
// PER_W=8. Each driven sector change that should produce a STEP pushes its
// expected SECTOR/DIR/PERIOD onto a queue; a monitor pops one entry per
// observed STEP pulse. Static outputs are checked at fixed points in between.
// -----------------------------------------------------------------------------
module tb_hall_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int PW   = 8;

    localparam logic [2:0] FWD [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          h1, h2, h3, clr;
    logic          h1_out, h2_out, h3_out;
    logic [2:0]    sector;
    logic          dir, step, stall, hall_fault;
    logic [PW-1:0] period;

    hall_conditioner #(
        .SYNC_STAGES (SYNC),
        .DEB_CYCLES  (DEB),
        .PER_W       (PW)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .H1         (h1),
        .H2         (h2),
        .H3         (h3),
        .CLR_FAULT  (clr),
        .H1_OUT     (h1_out),
        .H2_OUT     (h2_out),
        .H3_OUT     (h3_out),
        .SECTOR     (sector),
        .DIR        (dir),
        .STEP       (step),
        .PERIOD     (period),
        .STALL      (stall),
        .HALL_FAULT (hall_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         id;
        logic [2:0] sector;
        logic       dir;
        logic [7:0] period;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   last_step_cyc = 0;
    bit   armed = 1'b0;
    int   step_id = 0;

    function automatic logic [2:0] dec(input logic [2:0] c);
        case (c)
            3'b001:  return 3'd1;
            3'b101:  return 3'd2;
            3'b100:  return 3'd3;
            3'b110:  return 3'd4;
            3'b010:  return 3'd5;
            3'b011:  return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] c);
        {h3, h2, h1} = c;
    endtask

    // Input-to-STEP latency is constant, so STEP spacing equals drive spacing.
    task automatic step_to(input logic [2:0] c, input logic d);
        exp_t e;
        int   gap;
        drive(c);
        gap      = cyc - last_step_cyc;
        e.id     = step_id;
        e.sector = dec(c);
        e.dir    = d;
        e.period = (armed && gap <= 255) ? 8'(gap) : 8'd0;
        step_id++;
        armed         = 1'b1;
        last_step_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && step === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_step", step, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("step%0d_sector", mon_e.id), sector, mon_e.sector);
                chk($sformatf("step%0d_dir", mon_e.id), dir, mon_e.dir);
                chk($sformatf("step%0d_period", mon_e.id), period, mon_e.period);
                chk($sformatf("step%0d_stall", mon_e.id), stall, 1'b0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        drive(3'b000);
        tick(3);
        chk("rst_hout", {h3_out, h2_out, h1_out}, 3'b000);
        chk("rst_sector", sector, 3'd0);
        chk("rst_dir", dir, 1'b1);
        chk("rst_step", step, 1'b0);
        chk("rst_period", period, 8'd0);
        chk("rst_stall", stall, 1'b1);
        chk("rst_fault", hall_fault, 1'b0);

        rst_n = 1'b1;
        tick(10);
        chk("idle000_fault", hall_fault, 1'b0);
        chk("idle000_sector", sector, 3'd0);
        chk("idle000_stall", stall, 1'b1);

        // Establish sector 1: no STEP, exact latency SYNC+DEB
        drive(3'b001);
        tick(SYNC + DEB);
        chk("est_sector_early", sector, 3'd0);
        tick(1);
        chk("est_sector", sector, 3'd1);
        chk("est_hout", {h3_out, h2_out, h1_out}, 3'b001);
        chk("est_stall", stall, 1'b1);
        chk("est_fault", hall_fault, 1'b0);
        chk("est_dir", dir, 1'b1);
        tick(20);

        // Full forward revolution at 50 cycles/step
        for (int i = 0; i < 6; i++) begin
            step_to(FWD[i], 1'b1);
            tick(50);
        end
        chk("fwd_sector", sector, 3'd1);
        chk("fwd_dir", dir, 1'b1);
        chk("fwd_period", period, 8'd50);
        chk("fwd_stall", stall, 1'b0);

        // Reverse 011 -> 010 -> 110
        step_to(3'b011, 1'b0);
        tick(30);
        step_to(3'b010, 1'b0);
        tick(37);
        step_to(3'b110, 1'b0);
        tick(20);
        chk("rev_sector", sector, 3'd4);
        chk("rev_dir", dir, 1'b0);
        chk("rev_period", period, 8'd37);

        // 3-cycle glitch to 000 is filtered out
        drive(3'b000);
        tick(DEB - 1);
        drive(3'b110);
        tick(20);
        chk("glitch_sector", sector, 3'd4);
        chk("glitch_hout", {h3_out, h2_out, h1_out}, 3'b110);
        chk("glitch_fault", hall_fault, 1'b0);
        chk("glitch_stall", stall, 1'b0);
        chk("glitch_period", period, 8'd37);

        // 4-cycle 000 is accepted as an invalid code
        drive(3'b000);
        tick(DEB);
        drive(3'b110);
        tick(SYNC + DEB + 1 - DEB);
        armed = 1'b0;
        chk("inval_sector", sector, 3'd0);
        chk("inval_hout", {h3_out, h2_out, h1_out}, 3'b000);
        chk("inval_fault", hall_fault, 1'b1);
        chk("inval_stall", stall, 1'b1);
        chk("inval_period", period, 8'd0);
        tick(10);
        chk("reest_sector", sector, 3'd4);
        chk("reest_fault_sticky", hall_fault, 1'b1);
        pulse_clr();
        chk("clr_fault", hall_fault, 1'b0);
        tick(5);

        // Jump S4 -> S1 with CLR_FAULT on the same edge: set wins
        drive(3'b001);
        tick(SYNC + DEB);
        pulse_clr();
        chk("jump3_fault", hall_fault, 1'b1);
        chk("jump3_sector", sector, 3'd1);
        chk("jump3_dir", dir, 1'b0);
        chk("jump3_stall", stall, 1'b1);
        chk("jump3_period", period, 8'd0);
        pulse_clr();
        chk("jump3_clr", hall_fault, 1'b0);
        tick(10);

        // Jump S1 -> S3
        drive(3'b100);
        tick(SYNC + DEB + 1);
        chk("jump2_fault", hall_fault, 1'b1);
        chk("jump2_sector", sector, 3'd3);
        chk("jump2_dir", dir, 1'b0);
        tick(5);
        chk("jump2_fault_sticky", hall_fault, 1'b1);
        pulse_clr();
        chk("jump2_clr", hall_fault, 1'b0);

        // Measure, then hold until the period counter saturates
        step_to(3'b110, 1'b1);
        tick(40);
        step_to(3'b010, 1'b1);
        tick(SYNC + DEB + 255);
        chk("presat_stall", stall, 1'b0);
        chk("presat_period", period, 8'd40);
        tick(1);
        chk("sat_stall", stall, 1'b1);
        chk("sat_period", period, 8'd0);
        tick(300 - (SYNC + DEB + 256));
        step_to(3'b011, 1'b1);
        tick(45);
        chk("rearm_stall", stall, 1'b0);
        chk("rearm_period", period, 8'd0);
        step_to(3'b001, 1'b1);
        tick(255);
        chk("restore_period", period, 8'd45);
        chk("restore_stall", stall, 1'b0);

        // STEP on the very cycle the counter would saturate
        step_to(3'b101, 1'b1);
        tick(10);
        chk("stepsat_period", period, 8'd255);
        chk("stepsat_stall", stall, 1'b0);
        chk("stepsat_sector", sector, 3'd2);

        // Asynchronous reset mid-operation
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_sector", sector, 3'd0);
        chk("midrst_period", period, 8'd0);
        chk("midrst_stall", stall, 1'b1);
        chk("midrst_hout", {h3_out, h2_out, h1_out}, 3'b000);
        chk("midrst_dir", dir, 1'b1);
        @(negedge clk);
        tick(2);
        rst_n = 1'b1;
        armed = 1'b0;
        tick(SYNC + DEB);
        chk("postrst_sector_early", sector, 3'd0);
        tick(1);
        chk("postrst_sector", sector, 3'd2);
        chk("postrst_stall", stall, 1'b1);
        chk("postrst_fault", hall_fault, 1'b0);
        tick(5);

        chk("sb_pending", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
